pipe_sched: RTL and testbench
=============================

PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 Parameters SHALL be:
- EXP_VECTOR, default 30'h0000_0040, word address of the exception handler.
- BUS_TIMEOUT, default 8'd255, number of consecutive mem_busy cycles that raises a bus error.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_busy  in  1  IF bus access not complete.
- mem_busy  in  1  MEM bus access not complete.
- ld_hazard  in  1  load-use hazard from the ID decoder.
- mem_en  in  1  MEM stage holds a valid instruction.
- mem_pc  in  30  word address of the MEM-stage instruction.
- mem_exp_code  in  3  exception code carried by the MEM-stage instruction.
- mem_ctrl_op  in  2  0 = NOP, 1 = WRCR, 2 = EXRT.
- mem_cr_addr  in  5  control register index for WRCR.
- mem_wr_data  in  32  WRCR write data.
- irq  in  1  external interrupt request, level.
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the stage register.
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  invalidate the stage register.
- pc_load  out  1  IF loads new_pc.
- new_pc  out  30  redirect target.
- exe_mode  out  1  0 = kernel, 1 = user.
- int_en  out  1  interrupt enable.
- epc  out  30  saved exception PC.
- exp_code_q  out  3  last accepted exception code.

Function
REQ-003 The block SHALL compute stall = if_busy | mem_busy.
REQ-004 In IDLE:
- id_stall, ex_stall and mem_stall SHALL each equal stall.
- if_stall SHALL equal stall | ld_hazard.
- id_flush SHALL equal ld_hazard & ~stall, inserting a bubble.
REQ-005 An event SHALL be accepted only in IDLE with mem_en = 1 and mem_busy = 0. Priority, highest first:
- mem_exp_code != 0: the code is taken as-is.
- Bus timeout: code 3'd7.
- irq & int_en: code 3'd1.
- mem_ctrl_op = EXRT.
REQ-006 Exception acceptance (any code) SHALL register, at the next edge:
- epc <= mem_pc;
- exp_code_q <= code;
- saved_mode <= exe_mode and saved_ie <= int_en;
- exe_mode <= 0 and int_en <= 0;
- state <= FLUSH with target = EXP_VECTOR.
REQ-007 EXRT acceptance SHALL restore exe_mode <= saved_mode and int_en <= saved_ie, and move to FLUSH with target = epc.
REQ-008 A WRCR with mem_en = 1 and mem_busy = 0, and no higher-priority event, SHALL write at the next edge:
- addr 0: exe_mode <= data[0], int_en <= data[1];
- addr 1: epc <= data[31:2];
- other addresses: ignored.
WRCR causes no flush.
REQ-009 FLUSH SHALL last exactly one cycle:
- all four flush outputs = 1;
- all four stall outputs = 0;
- pc_load = 1 and new_pc = target;
- then return to IDLE.
REQ-010 In IDLE, pc_load SHALL be 0 and new_pc SHALL be 0.
REQ-011 The timeout counter (8-bit):
- increments each cycle mem_busy = 1 and clears when mem_busy = 0;
- saturates at BUS_TIMEOUT;
- while saturated with mem_en = 1, is treated as event code 7, overriding the mem_busy = 0 acceptance condition;
- clears on entry to FLUSH.
REQ-012 In FLUSH, irq, WRCR and new exceptions SHALL be ignored and not latched; a level irq is re-evaluated in IDLE.
REQ-013 irq SHALL be ignored while int_en = 0 or while a MEM-stage exception is present.

Reset
REQ-014 On a clock edge with reset = 1, the block SHALL set:
- state = IDLE;
- exe_mode = 0, int_en = 0;
- epc = 0, exp_code_q = 0;
- saved_mode = 0, saved_ie = 0;
- counter = 0.
REQ-015 While reset = 1, all stall, flush and pc_load outputs SHALL be 0, and new_pc SHALL be 0.
REQ-016 Reset asserted during FLUSH SHALL abort the redirect, with no pc_load on the following cycle.

Verification
REQ-017 The bench SHALL cover these scenarios:
- ld_hazard = 1, no busy -> if_stall = 1, id_flush = 1, other stalls and flushes 0, pc_load = 0.
- mem_en = 1, mem_exp_code = 5, mem_pc = 30'h123, exe_mode = 1, int_en = 1 -> next cycle: 4 flushes = 1, pc_load = 1, new_pc = 30'h40, epc = 30'h123, exp_code_q = 5, exe_mode = 0, int_en = 0.
- After that, EXRT with mem_en = 1 -> next cycle: new_pc = 30'h123, exe_mode = 1, int_en = 1.
- irq = 1 with int_en = 0 -> no flush. WRCR addr 0, data 32'h2 -> int_en = 1; then irq -> exp_code_q = 1.
- mem_busy held 255 cycles with mem_en = 1 -> FLUSH with exp_code_q = 7. mem_busy held 254 cycles then released -> no exception.
- Exception accepted and reset asserted in the FLUSH cycle -> pc_load = 0 and all state at REQ-014 values.

Source files
------------

// File: rtl/pipe_sched.sv
// Pipeline hazard/exception scheduler: stall and flush control, exception entry/return,
// control-register writes and a MEM bus watchdog.
module pipe_sched #(
  parameter logic [29:0] EXP_VECTOR  = 30'h0000_0040,
  parameter logic [7:0]  BUS_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic        mem_en,
  input  logic [29:0] mem_pc,
  input  logic [2:0]  mem_exp_code,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [4:0]  mem_cr_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        irq,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic        pc_load,
  output logic [29:0] new_pc,
  output logic        exe_mode,
  output logic        int_en,
  output logic [29:0] epc,
  output logic [2:0]  exp_code_q
);

  localparam logic [1:0] OpWrcr = 2'd1;
  localparam logic [1:0] OpExrt = 2'd2;

  typedef enum logic {StIdle, StFlush} state_e;

  state_e      state_q;
  logic [29:0] target_q;
  logic        saved_mode_q;
  logic        saved_ie_q;
  logic [7:0]  cnt_q;

  logic       stall;
  logic       timeout;
  logic       accept;
  logic       take_exp;
  logic       take_exrt;
  logic       take_wrcr;
  logic [2:0] exp_code_sel;

  assign stall   = if_busy | mem_busy;
  assign timeout = (cnt_q == BUS_TIMEOUT);
  // A saturated watchdog lets the MEM instruction be taken even while the bus is still busy.
  assign accept  = (state_q == StIdle) & mem_en & (~mem_busy | timeout);

  assign take_exp  = accept & ((mem_exp_code != 3'd0) | timeout | (irq & int_en));
  assign take_exrt = accept & ~take_exp & (mem_ctrl_op == OpExrt);
  assign take_wrcr = accept & ~take_exp & (mem_ctrl_op == OpWrcr);

  always_comb begin
    exp_code_sel = 3'd1;
    if (mem_exp_code != 3'd0) begin
      exp_code_sel = mem_exp_code;
    end else if (timeout) begin
      exp_code_sel = 3'd7;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      target_q     <= '0;
      saved_mode_q <= 1'b0;
      saved_ie_q   <= 1'b0;
      cnt_q        <= '0;
      exe_mode     <= 1'b0;
      int_en       <= 1'b0;
      epc          <= '0;
      exp_code_q   <= '0;
    end else begin
      if (take_exp || take_exrt) begin
        cnt_q <= '0;
      end else if (mem_busy) begin
        cnt_q <= timeout ? cnt_q : cnt_q + 8'd1;
      end else begin
        cnt_q <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (take_exp) begin
            epc          <= mem_pc;
            exp_code_q   <= exp_code_sel;
            saved_mode_q <= exe_mode;
            saved_ie_q   <= int_en;
            exe_mode     <= 1'b0;
            int_en       <= 1'b0;
            target_q     <= EXP_VECTOR;
            state_q      <= StFlush;
          end else if (take_exrt) begin
            exe_mode <= saved_mode_q;
            int_en   <= saved_ie_q;
            target_q <= epc;
            state_q  <= StFlush;
          end else if (take_wrcr) begin
            if (mem_cr_addr == 5'd0) begin
              exe_mode <= mem_wr_data[0];
              int_en   <= mem_wr_data[1];
            end else if (mem_cr_addr == 5'd1) begin
              epc <= mem_wr_data[31:2];
            end
          end
        end
        StFlush: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    pc_load   = 1'b0;
    new_pc    = '0;
    if (!reset) begin
      if (state_q == StFlush) begin
        if_flush  = 1'b1;
        id_flush  = 1'b1;
        ex_flush  = 1'b1;
        mem_flush = 1'b1;
        pc_load   = 1'b1;
        new_pc    = target_q;
      end else begin
        if_stall  = stall | ld_hazard;
        id_stall  = stall;
        ex_stall  = stall;
        mem_stall = stall;
        id_flush  = ld_hazard & ~stall;
      end
    end
  end

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: a per-cycle reference model checked on every negedge,
// plus literal checks on the key scenarios.
module tb_pipe_sched;

  localparam logic [29:0] ExpVec = 30'h40;
  localparam int          BusTo  = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_busy, mem_busy, ld_hazard, mem_en, irq;
  logic [29:0] mem_pc;
  logic [2:0]  mem_exp_code;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_cr_addr;
  logic [31:0] mem_wr_data;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        pc_load, exe_mode, int_en;
  logic [29:0] new_pc, epc;
  logic [2:0]  exp_code_q;

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  always #5 clk = ~clk;

  pipe_sched dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
    .mem_en(mem_en), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code), .mem_ctrl_op(mem_ctrl_op),
    .mem_cr_addr(mem_cr_addr), .mem_wr_data(mem_wr_data), .irq(irq),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .pc_load(pc_load), .new_pc(new_pc), .exe_mode(exe_mode), .int_en(int_en), .epc(epc),
    .exp_code_q(exp_code_q)
  );

  // Reference model: architectural state plus "in redirect" flag and busy run length.
  logic        m_flush, m_mode, m_ie, m_smode, m_sie;
  logic [29:0] m_target, m_epc;
  logic [2:0]  m_code;
  int          m_run;

  // Event chosen this cycle: -1 none, 1..7 exception code, 8 return, 9 control write.
  function automatic int pick();
    bit to;
    to = (m_run >= BusTo);
    if (m_flush || !mem_en || (mem_busy && !to)) return -1;
    if (mem_exp_code != 3'd0) return int'(mem_exp_code);
    if (to) return 7;
    if (irq && m_ie) return 1;
    if (mem_ctrl_op == 2'd2) return 8;
    if (mem_ctrl_op == 2'd1) return 9;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_flush <= 1'b0; m_mode <= 1'b0; m_ie <= 1'b0; m_smode <= 1'b0; m_sie <= 1'b0;
      m_target <= '0; m_epc <= '0; m_code <= '0; m_run <= 0;
    end else begin
      m_flush <= 1'b0;
      m_run   <= mem_busy ? ((m_run < BusTo) ? m_run + 1 : m_run) : 0;
      if (pick() >= 1 && pick() <= 7) begin
        m_epc <= mem_pc; m_code <= 3'(pick()); m_smode <= m_mode; m_sie <= m_ie;
        m_mode <= 1'b0; m_ie <= 1'b0; m_flush <= 1'b1; m_target <= ExpVec; m_run <= 0;
      end else if (pick() == 8) begin
        m_mode <= m_smode; m_ie <= m_sie; m_flush <= 1'b1; m_target <= m_epc; m_run <= 0;
      end else if (pick() == 9) begin
        if (mem_cr_addr == 5'd0) begin
          m_mode <= mem_wr_data[0]; m_ie <= mem_wr_data[1];
        end else if (mem_cr_addr == 5'd1) begin
          m_epc <= mem_wr_data[31:2];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      logic [8:0]  e_ctl;
      logic [29:0] e_pc;
      logic        s;
      s = if_busy | mem_busy;
      if (reset) begin
        e_ctl = '0; e_pc = '0;
      end else if (m_flush) begin
        e_ctl = 9'b0000_1111_1; e_pc = m_target;
      end else begin
        e_ctl = {s | ld_hazard, s, s, s, 1'b0, ld_hazard & ~s, 1'b0, 1'b0, 1'b0};
        e_pc  = '0;
      end
      chk("model_ctl", 36'({if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush,
                            ex_flush, mem_flush, pc_load}), 36'(e_ctl));
      chk("model_new_pc", 36'(new_pc), 36'(e_pc));
      chk("model_state", {exe_mode, int_en, epc, exp_code_q}, {m_mode, m_ie, m_epc, m_code});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0; irq = 0;
    mem_exp_code = 0; mem_ctrl_op = 0; mem_cr_addr = 0; mem_wr_data = 0;
  endtask

  task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
    idle_in(); mem_en = 1; mem_ctrl_op = 2'd1; mem_cr_addr = a; mem_wr_data = d;
  endtask

  initial begin
    idle_in(); mem_pc = '0; reset = 1; if_busy = 1;
    step(); step();
    armed = 1'b1;
    @(negedge clk);
    chk("rst_if_stall", 36'(if_stall), 36'd0);
    chk("rst_pc_load", 36'(pc_load), 36'd0);
    chk("rst_epc", 36'(epc), 36'd0);

    step(); reset = 0; idle_in(); ld_hazard = 1;
    @(negedge clk);
    chk("ld_if_stall", 36'(if_stall), 36'd1);
    chk("ld_id_flush", 36'(id_flush), 36'd1);
    chk("ld_id_stall", 36'(id_stall), 36'd0);
    chk("ld_pc_load", 36'(pc_load), 36'd0);

    step(); wrcr(5'd0, 32'h3);
    step(); idle_in(); mem_en = 1; mem_exp_code = 3'd5; mem_pc = 30'h123;
    @(negedge clk);
    chk("wrcr_mode_ie", 36'({exe_mode, int_en}), 36'b11);

    step(); idle_in();
    @(negedge clk);
    chk("exc_flushes", 36'({if_flush, id_flush, ex_flush, mem_flush}), 36'hf);
    chk("exc_pc_load", 36'(pc_load), 36'd1);
    chk("exc_new_pc", 36'(new_pc), 36'h40);
    chk("exc_epc", 36'(epc), 36'h123);
    chk("exc_code", 36'(exp_code_q), 36'd5);
    chk("exc_mode_ie", 36'({exe_mode, int_en}), 36'b00);

    step(); idle_in(); mem_en = 1; mem_ctrl_op = 2'd2;
    step(); idle_in();
    @(negedge clk);
    chk("exrt_new_pc", 36'(new_pc), 36'h123);
    chk("exrt_mode_ie", 36'({exe_mode, int_en}), 36'b11);

    step(); wrcr(5'd0, 32'h0);
    step(); idle_in(); irq = 1; mem_en = 1; mem_pc = 30'h200;
    step(); wrcr(5'd0, 32'h2); irq = 1;
    @(negedge clk);
    chk("irq_masked_pc_load", 36'(pc_load), 36'd0);
    step(); idle_in(); irq = 1; mem_en = 1; mem_pc = 30'h55;
    @(negedge clk);
    chk("wrcr_int_en", 36'(int_en), 36'd1);
    step(); idle_in();
    @(negedge clk);
    chk("irq_pc_load", 36'(pc_load), 36'd1);
    chk("irq_code", 36'(exp_code_q), 36'd1);
    chk("irq_epc", 36'(epc), 36'h55);

    step(); idle_in(); mem_busy = 1; mem_en = 1; mem_pc = 30'h77;
    @(negedge clk);
    chk("busy_mem_stall", 36'(mem_stall), 36'd1);
    repeat (254) step();
    mem_busy = 0;
    step(); idle_in();
    @(negedge clk);
    chk("busy254_pc_load", 36'(pc_load), 36'd0);

    step(); mem_busy = 1; mem_en = 1;
    repeat (255) step();
    mem_busy = 0;
    step(); idle_in();
    @(negedge clk);
    chk("to_pc_load", 36'(pc_load), 36'd1);
    chk("to_code", 36'(exp_code_q), 36'd7);
    chk("to_epc", 36'(epc), 36'h77);

    step(); idle_in(); mem_en = 1; mem_exp_code = 3'd2; mem_pc = 30'h99;
    step(); idle_in(); reset = 1;
    @(negedge clk);
    chk("rstfl_pc_load", 36'(pc_load), 36'd0);
    chk("rstfl_if_flush", 36'(if_flush), 36'd0);
    step(); reset = 0;
    @(negedge clk);
    chk("after_rst_pc_load", 36'(pc_load), 36'd0);
    chk("after_rst_state", {exe_mode, int_en, epc, exp_code_q}, 36'd0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
